// File: rtl/audio_pkg.sv
// audio_pkg: envelope state encoding and width helpers shared by the tone output stage.
package audio_pkg;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_e;

    localparam int VOL_BITS = 4;

    function automatic int env_max(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/pwm_dac.sv
// pwm_dac: free-running PWM with duty latched at period start and a registered compare.
module pwm_dac #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_q;

    // Duty only changes at the wrap so each period is a clean single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            duty_q <= (cnt_q == '0) ? duty_in : duty_q;
            pwm_q  <= cnt_q < duty_q;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/tone_envelope_pwm.sv
// tone_envelope_pwm: ADSR-style envelope on the tone square wave, volume scaling and PWM amp drive.
module tone_envelope_pwm
    import audio_pkg::*;
#(
    parameter int PWM_BITS            = 8,
    parameter int ATTACK_STEP_CYCLES  = 4096,
    parameter int RELEASE_STEP_CYCLES = 8192
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                music_enable,
    input  logic                tone_in,
    input  logic                note_active,
    input  logic [3:0]          volume,
    output logic                aud_pwm,
    output logic                aud_sd,
    output logic [PWM_BITS-1:0] env_level,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] ENV_MAX = PWM_BITS'(env_max(PWM_BITS));
    localparam int STEP_MAX = (ATTACK_STEP_CYCLES > RELEASE_STEP_CYCLES) ?
                              ATTACK_STEP_CYCLES : RELEASE_STEP_CYCLES;
    localparam int TW = $clog2(STEP_MAX + 1);
    localparam logic [TW-1:0] A_LAST = TW'(ATTACK_STEP_CYCLES - 1);
    localparam logic [TW-1:0] R_LAST = TW'(RELEASE_STEP_CYCLES - 1);

    env_state_e                   state_q, state_d;
    logic [PWM_BITS-1:0]          env_q, env_d;
    logic [TW-1:0]                tmr_q, tmr_d;
    logic                         note_q;
    logic                         busy_q;
    logic                         rise;
    logic [PWM_BITS+VOL_BITS-1:0] prod;
    logic [PWM_BITS-1:0]          amp;
    logic [PWM_BITS-1:0]          duty_next;

    assign rise = note_active & ~note_q;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        tmr_d   = tmr_q + 1'b1;
        case (state_q)
            IDLE: begin
                env_d = '0;
                tmr_d = '0;
                if (rise) state_d = ATTACK;
            end
            ATTACK: begin
                if (!note_active) begin
                    state_d = RELEASE;
                end else if (env_q == ENV_MAX) begin
                    state_d = SUSTAIN;
                end else if (tmr_q == A_LAST) begin
                    env_d = env_q + 1'b1;
                    tmr_d = '0;
                    if (env_d == ENV_MAX) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                env_d = ENV_MAX;
                tmr_d = '0;
                if (!note_active) state_d = RELEASE;
            end
            default: begin
                if (rise) begin
                    state_d = ATTACK;
                end else if (env_q == '0) begin
                    state_d = IDLE;
                end else if (tmr_q == R_LAST) begin
                    env_d = env_q - 1'b1;
                    tmr_d = '0;
                    if (env_d == '0) state_d = IDLE;
                end
            end
        endcase
        // Disabling music cuts straight to silence with no release ramp.
        if (!music_enable) begin
            state_d = IDLE;
            env_d   = '0;
        end
        if (state_d != state_q) tmr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            env_q   <= '0;
            tmr_q   <= '0;
            note_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            tmr_q   <= tmr_d;
            note_q  <= note_active;
            busy_q  <= state_q != IDLE;
        end
    end

    assign prod      = env_q * volume;
    assign amp       = PWM_BITS'(prod >> VOL_BITS);
    assign duty_next = tone_in ? amp : '0;

    pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty_in (duty_next),
        .pwm_out (aud_pwm)
    );

    assign aud_sd    = busy_q;
    assign busy      = busy_q;
    assign env_level = env_q;

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// tb_tone_envelope_pwm: scoreboard bench against a ramp-equation model of envelope and PWM output.
module tb_tone_envelope_pwm;

    localparam int P = 4;
    localparam int A = 2;
    localparam int R = 3;
    localparam int MAX = 15;
    localparam int PER = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         music_enable;
    logic         tone_in;
    logic         note_active;
    logic [3:0]   volume;
    logic         aud_pwm;
    logic         aud_sd;
    logic [P-1:0] env_level;
    logic         busy;

    always #5 clk = ~clk;

    tone_envelope_pwm #(
        .PWM_BITS            (P),
        .ATTACK_STEP_CYCLES  (A),
        .RELEASE_STEP_CYCLES (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .music_enable (music_enable),
        .tone_in      (tone_in),
        .note_active  (note_active),
        .volume       (volume),
        .aud_pwm      (aud_pwm),
        .aud_sd       (aud_sd),
        .env_level    (env_level),
        .busy         (busy)
    );

    typedef struct packed {
        logic [3:0] env;
        logic       bsy;
        logic       pwm;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    // Model: phase 0 idle, 1 attack, 2 sustain, 3 release; env is a linear ramp
    // from (t0, e0) clamped at the ends.
    int k, ph, t0, e0, env_m, duty_old;
    bit note_prev;

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", n, k, act, exp);
        end
    endtask

    task automatic step();
        int  amp;
        bit  prev_busy, rise, pw;
        exp_t e;
        @(posedge clk);
        if (rst) begin
            k = 0; ph = 0; t0 = 0; e0 = 0; env_m = 0; duty_old = 0; note_prev = 0;
            q.push_back('0);
        end else begin
            k++;
            amp = (env_m * int'(volume)) / 16;
            prev_busy = (ph != 0);
            rise = note_active && !note_prev;
            if (!music_enable) begin
                ph = 0; env_m = 0;
            end else if (ph == 0) begin
                env_m = 0;
                if (rise) begin ph = 1; t0 = k; e0 = 0; end
            end else if (ph == 1) begin
                if (!note_active) begin
                    ph = 3; t0 = k; e0 = env_m;
                end else begin
                    env_m = e0 + (k - t0) / A;
                    if (env_m >= MAX) begin env_m = MAX; ph = 2; end
                end
            end else if (ph == 2) begin
                env_m = MAX;
                if (!note_active) begin ph = 3; t0 = k; e0 = env_m; end
            end else begin
                if (rise) begin
                    ph = 1; t0 = k; e0 = env_m;
                end else begin
                    env_m = e0 - (k - t0) / R;
                    if (env_m <= 0) begin env_m = 0; ph = 0; end
                end
            end
            pw = ((k - 1) % PER) < duty_old;
            if ((k - 1) % PER == 0) duty_old = tone_in ? amp : 0;
            note_prev = note_active;
            e.env = 4'(env_m);
            e.bsy = prev_busy;
            e.pwm = pw;
            q.push_back(e);
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("env_level", 8'(env_level), 8'(e.env));
            chk("busy", 8'(busy), 8'(e.bsy));
            chk("aud_sd", 8'(aud_sd), 8'(e.bsy));
            chk("aud_pwm", 8'(aud_pwm), 8'(e.pwm));
        end
    end

    task automatic run(input int n, input bit rand_tone);
        repeat (n) begin
            if (rand_tone) tone_in = 1'($urandom);
            step();
        end
    endtask

    task automatic until_env(input int target, input int bound);
        int i;
        for (i = 0; i < bound && env_m != target; i++) step();
        if (env_m != target) begin
            errs++;
            checks++;
            $display("FAIL wait_env cycle=%0d actual=%0d expected=%0d", k, env_m, target);
        end
    endtask

    task automatic count_high(input string n, input int exp);
        int c = 0;
        repeat (PER) begin
            step();
            c += int'(aud_pwm);
        end
        chk(n, 8'(c), 8'(exp));
    endtask

    initial begin
        rst = 1'b1;
        music_enable = 1'($urandom);
        tone_in = 1'($urandom);
        note_active = 1'($urandom);
        volume = 4'($urandom);
        step();
        step();
        rst = 1'b0;
        music_enable = 1'b1;
        note_active = 1'b0;
        volume = 4'd15;
        run(3, 1);
        note_active = 1'b1;
        run(40, 1);
        note_active = 1'b0;
        run(50, 1);

        volume = 4'd8;
        tone_in = 1'b1;
        note_active = 1'b1;
        run(80, 0);
        while (k % PER != 0) step();
        count_high("pwm_high_vol8", 7);
        tone_in = 1'b0;
        run(PER + 1, 0);
        count_high("pwm_high_tone0", 0);

        volume = 4'd15;
        note_active = 1'b0;
        until_env(6, 200);
        note_active = 1'b1;
        run(1, 1);
        chk("resume_no_dip", 8'(env_level), 8'd6);
        until_env(9, 200);
        note_active = 1'b0;
        run(40, 1);

        note_active = 1'b1;
        run(50, 1);
        music_enable = 1'b0;
        step();
        chk("env_off", 8'(env_level), 8'd0);
        step();
        chk("busy_off", 8'(busy), 8'd0);
        run(40, 1);

        music_enable = 1'b1;
        repeat (900) begin
            if ($urandom_range(0, 19) == 0) note_active = ~note_active;
            if ($urandom_range(0, 29) == 0) volume = 4'($urandom);
            if ($urandom_range(0, 3) == 0) tone_in = ~tone_in;
            music_enable = $urandom_range(0, 99) != 0;
            step();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
